// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating a fetch port and a data port onto an
// 8-bit RAM with one cycle of read latency; assembles/splits 1, 2 or 4 byte words.
module mem_ctrl #(
  parameter int RAM_LAT = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_re,
  input  logic [31:0] if_addr,
  input  logic [2:0]  if_len,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [2:0]  mem_len,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  ram_din,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  output logic [31:0] rdata,
  output logic        if_done,
  output logic        mem_done,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] LAT = 3'(RAM_LAT);

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_len;
  logic [31:0] r_wdata;
  logic        r_port;   // 1 = data port, 0 = fetch port
  logic [2:0]  r_k;
  logic [31:0] r_rdata;

  logic [31:0] w_addr_k;
  logic [1:0]  w_cap;

  function automatic logic [2:0] decode_len(input logic [2:0] len);
    return (len == 3'd1 || len == 3'd2) ? len : 3'd4;
  endfunction

  assign w_addr_k = r_addr + {29'd0, r_k};
  // The byte addressed in cycle k arrives LAT cycles later, so capture lags k.
  assign w_cap    = 2'(r_k - LAT);

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_wdata <= '0;
      r_port  <= 1'b0;
      r_k     <= '0;
      r_rdata <= '0;
    end else if (rdy_in) begin
      case (r_state)
        S_IDLE: begin
          if (mem_we || mem_re) begin
            r_port  <= 1'b1;
            r_addr  <= mem_addr;
            r_len   <= decode_len(mem_len);
            r_wdata <= mem_wdata;
            r_k     <= '0;
            r_rdata <= '0;
            r_state <= mem_we ? S_WRITE : S_READ;
          end else if (if_re) begin
            r_port  <= 1'b0;
            r_addr  <= if_addr;
            r_len   <= decode_len(if_len);
            r_wdata <= '0;
            r_k     <= '0;
            r_rdata <= '0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (r_k >= LAT) r_rdata[{w_cap, 3'b000} +: 8] <= ram_din;
          if (r_k == r_len + LAT - 3'd1) r_state <= S_DONE;
          else                           r_k     <= r_k + 3'd1;
        end
        S_WRITE: begin
          if (r_k == r_len - 3'd1) r_state <= S_DONE;
          else                     r_k     <= r_k + 3'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the state decode, so no latch is inferred.
  always_comb begin
    ram_a    = '0;
    ram_dout = '0;
    ram_wr   = 1'b0;
    if (r_state == S_READ) begin
      ram_a = w_addr_k;
    end else if (r_state == S_WRITE) begin
      ram_a    = w_addr_k;
      ram_dout = r_wdata[{r_k[1:0], 3'b000} +: 8];
      ram_wr   = rdy_in & rst_in;
    end
  end

  assign rdata    = r_rdata;
  assign busy     = (r_state != S_IDLE);
  assign if_done  = (r_state == S_DONE) & ~r_port;
  assign mem_done = (r_state == S_DONE) &  r_port;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized transactions
// compared against a byte-level reference memory and a cycle-count model.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_re;
  logic [31:0] if_addr;
  logic [2:0]  if_len;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [2:0]  mem_len;
  logic [31:0] mem_wdata;
  logic [7:0]  ram_din = 8'h00;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [31:0] rdata;
  logic        if_done;
  logic        mem_done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata;

  logic [7:0] ram_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_ctrl #(.RAM_LAT(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_re(if_re), .if_addr(if_addr), .if_len(if_len),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .ram_din(ram_din), .ram_a(ram_a), .ram_dout(ram_dout),
    .ram_wr(ram_wr), .rdata(rdata), .if_done(if_done), .mem_done(mem_done), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // RAM attached to the controller: shares the global enable, one cycle read latency.
  always @(posedge clk_in) begin
    if (rdy_in) begin
      ram_din <= ram_mem.exists(ram_a) ? ram_mem[ram_a] : 8'h00;
      if (ram_wr) ram_mem[ram_a] = ram_dout;
    end
  end

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : 8'h00;
  endfunction

  function automatic int eff_len(input logic [2:0] l);
    return (l == 3'd1 || l == 3'd2) ? int'(l) : 4;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram_mem[a] = b;
    ref_mem[a] = b;
  endtask

  // kind: 0 fetch, 1 load, 2 store. stall_at = busy-cycle index at which rdy_in drops.
  task automatic run_txn(input string tag, input int kind, input logic [31:0] addr,
                         input logic [2:0] len, input logic [31:0] wdata,
                         input int stall_at, input int stall_cyc);
    int n, cycles, idx, stall_left, exp_cycles, exp_trace;
    bit seen;
    logic [31:0] exp_rdata;
    logic [31:0] q_a[$];
    logic        q_wr[$];
    logic [7:0]  q_d[$];
    n = eff_len(len);
    exp_rdata = '0;
    if (kind != 2)
      for (int i = 0; i < n; i++) exp_rdata[8*i +: 8] = ref_rd(addr + 32'(i));
    exp_cycles = ((kind == 2) ? n + 1 : n + 2) + ((stall_at >= 0) ? stall_cyc : 0);
    exp_trace  = (kind == 2) ? n : n + 1;
    case (kind)
      0:       begin if_re = 1'b1; if_addr = addr; if_len = len; end
      1:       begin mem_re = 1'b1; mem_addr = addr; mem_len = len; end
      default: begin mem_we = 1'b1; mem_addr = addr; mem_len = len; mem_wdata = wdata; end
    endcase
    cycles = 0; idx = 0; stall_left = 0; seen = 1'b0;
    for (int t = 0; t < 64 && !seen; t++) begin
      @(posedge clk_in);
      cycles++;
      @(negedge clk_in);
      if (((kind == 0) ? if_done : mem_done) === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (((kind == 0) ? mem_done : if_done) !== 1'b0) begin
          errors++;
          $display("FAIL %s wrong_port_done got 1 exp 0", tag);
        end
      end else if (rdy_in == 1'b0) begin
        checks++;
        if (ram_wr !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_ram_wr got %b exp 0", tag, ram_wr);
        end
        stall_left--;
        if (stall_left == 0) rdy_in = 1'b1;
      end else if (busy === 1'b1) begin
        if (idx == 0) begin
          checks++;
          if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL %s rdata_clear got %h exp 00000000", tag, rdata);
          end
        end
        q_a.push_back(ram_a); q_wr.push_back(ram_wr); q_d.push_back(ram_dout);
        if (idx == stall_at) begin rdy_in = 1'b0; stall_left = stall_cyc; end
        idx++;
      end
    end
    if_re = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout got no done exp done", tag);
      rdy_in = 1'b1;
      return;
    end
    checks++;
    if (cycles != exp_cycles) begin
      errors++;
      $display("FAIL %s cycles got %0d exp %0d", tag, cycles, exp_cycles);
    end
    checks++;
    if (idx != exp_trace) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d exp %0d", tag, idx, exp_trace);
    end
    for (int i = 0; i < idx && i < exp_trace; i++) begin
      checks++;
      if (q_wr[i] !== (kind == 2)) begin
        errors++;
        $display("FAIL %s ram_wr[%0d] got %b exp %0d", tag, i, q_wr[i], kind == 2);
      end
      if (i < n) begin
        checks++;
        if (q_a[i] !== addr + 32'(i)) begin
          errors++;
          $display("FAIL %s ram_a[%0d] got %h exp %h", tag, i, q_a[i], addr + 32'(i));
        end
        if (kind == 2) begin
          checks++;
          if (q_d[i] !== wdata[8*i +: 8]) begin
            errors++;
            $display("FAIL %s ram_dout[%0d] got %h exp %h", tag, i, q_d[i], wdata[8*i +: 8]);
          end
        end
      end
    end
    checks++;
    if (rdata !== exp_rdata) begin
      errors++;
      $display("FAIL %s rdata got %h exp %h", tag, rdata, exp_rdata);
    end
    last_rdata = rdata;
    if (kind == 2) begin
      for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
      for (int i = 0; i <= n; i++) begin
        checks++;
        if (ram_rd(addr + 32'(i)) !== ref_rd(addr + 32'(i))) begin
          errors++;
          $display("FAIL %s ram_byte[%h] got %h exp %h", tag, addr + 32'(i),
                   ram_rd(addr + 32'(i)), ref_rd(addr + 32'(i)));
        end
      end
    end
    @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if (busy !== 1'b0 || if_done !== 1'b0 || mem_done !== 1'b0 || rdata !== exp_rdata) begin
      errors++;
      $display("FAIL %s idle_after got busy=%b if_done=%b mem_done=%b rdata=%h exp 0 0 0 %h",
               tag, busy, if_done, mem_done, rdata, exp_rdata);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1;
    if_re = 1'b0; if_addr = '0; if_len = '0;
    mem_re = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_len = '0; mem_wdata = '0;
    @(posedge clk_in);
    if_re = 1'b1; mem_we = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if ({rdata, ram_a, ram_dout, ram_wr, if_done, mem_done, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdata=%h ram_a=%h ram_dout=%h wr=%b ifd=%b md=%b busy=%b exp all 0",
               rdata, ram_a, ram_dout, ram_wr, if_done, mem_done, busy);
    end
    if_re = 1'b0; mem_we = 1'b0;
    rst_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_fetch();
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    run_txn("fetch4", 0, 32'h100, 3'd4, 32'h0, -1, 0);
    checks++;
    if (last_rdata !== 32'h0000_0513) begin
      errors++;
      $display("FAIL fetch_value got %h exp 00000513", last_rdata);
    end
  endtask

  task automatic test_store_load();
    run_txn("store2", 2, 32'h2000, 3'd2, 32'hAABB_CCDD, -1, 0);
    run_txn("load2", 1, 32'h2000, 3'd2, 32'h0, -1, 0);
    checks++;
    if (last_rdata !== 32'h0000_CCDD) begin
      errors++;
      $display("FAIL store_load_value got %h exp 0000CCDD", last_rdata);
    end
  endtask

  task automatic test_simultaneous();
    int cyc, bad;
    bit seen;
    if_re = 1'b1; if_addr = 32'h100; if_len = 3'd2;
    mem_re = 1'b1; mem_addr = 32'h101; mem_len = 3'd1;
    seen = 1'b0; cyc = 0; bad = 0;
    for (int t = 0; t < 32 && !seen; t++) begin
      @(posedge clk_in); cyc++;
      @(negedge clk_in);
      if (if_done !== 1'b0) bad++;
      if (mem_done === 1'b1) seen = 1'b1;
    end
    mem_re = 1'b0;
    checks++;
    if (!seen || cyc != 3) begin
      errors++;
      $display("FAIL sim_data_first got seen=%0d cycles=%0d exp 1 3", seen, cyc);
    end
    checks++;
    if (rdata !== 32'h0000_0005) begin
      errors++;
      $display("FAIL sim_data_rdata got %h exp 00000005", rdata);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sim_fetch_early got %0d pulses exp 0", bad);
    end
    @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL sim_idle_gap got busy=%b exp 0", busy);
    end
    seen = 1'b0; cyc = 0; bad = 0;
    for (int t = 0; t < 32 && !seen; t++) begin
      @(posedge clk_in); cyc++;
      @(negedge clk_in);
      if (mem_done !== 1'b0) bad++;
      if (if_done === 1'b1) seen = 1'b1;
    end
    if_re = 1'b0;
    checks++;
    if (!seen || cyc != 4 || bad != 0) begin
      errors++;
      $display("FAIL sim_fetch_second got seen=%0d cycles=%0d stray=%0d exp 1 4 0", seen, cyc, bad);
    end
    checks++;
    if (rdata !== 32'h0000_0513) begin
      errors++;
      $display("FAIL sim_fetch_rdata got %h exp 00000513", rdata);
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic test_stall();
    logic [31:0] plain;
    for (int i = 0; i < 4; i++) preload(32'h500 + 32'(i), 8'(8'h3C + 8'(i * 17)));
    run_txn("load4_plain", 1, 32'h500, 3'd4, 32'h0, -1, 0);
    plain = last_rdata;
    run_txn("load4_stall", 1, 32'h500, 3'd4, 32'h0, 2, 3);
    checks++;
    if (last_rdata !== plain) begin
      errors++;
      $display("FAIL stall_rdata_same got %h exp %h", last_rdata, plain);
    end
  endtask

  task automatic test_wrap();
    preload(32'hFFFF_FFFF, 8'h9A);
    preload(32'h0000_0000, 8'h7E);
    run_txn("wrap_load2", 1, 32'hFFFF_FFFF, 3'd2, 32'h0, -1, 0);
    checks++;
    if (last_rdata !== 32'h0000_7E9A) begin
      errors++;
      $display("FAIL wrap_value got %h exp 00007E9A", last_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    for (int i = 0; i < 4; i++) preload(32'h3000 + 32'(i), 8'(8'h11 * (i + 1)));
    mem_we = 1'b1; mem_addr = 32'h3000; mem_len = 3'd4; mem_wdata = 32'hA1B2_C3D4;
    @(posedge clk_in); @(negedge clk_in);
    @(posedge clk_in); @(negedge clk_in);
    checks++;
    if (ram_wr !== 1'b1 || ram_a !== 32'h3001) begin
      errors++;
      $display("FAIL rstmid_pre got wr=%b a=%h exp 1 00003001", ram_wr, ram_a);
    end
    rst_in = 1'b0;
    #1;
    checks++;
    if (ram_wr !== 1'b0 || busy !== 1'b0 || mem_done !== 1'b0 || ram_a !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_immediate got wr=%b busy=%b md=%b a=%h exp 0 0 0 0",
               ram_wr, busy, mem_done, ram_a);
    end
    mem_we = 1'b0;
    ref_mem[32'h3000] = 8'hD4;
    bad = 0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk_in);
      if (mem_done !== 1'b0 || busy !== 1'b0) bad++;
    end
    rst_in = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk_in);
      if (mem_done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstmid_no_done got %0d bad cycles exp 0", bad);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram_rd(32'h3000 + 32'(i)) !== ref_rd(32'h3000 + 32'(i))) begin
        errors++;
        $display("FAIL rstmid_byte%0d got %h exp %h", i, ram_rd(32'h3000 + 32'(i)),
                 ref_rd(32'h3000 + 32'(i)));
      end
    end
  endtask

  task automatic test_random();
    int kind, n, st, sc;
    logic [31:0] a;
    logic [2:0] l;
    for (int i = 0; i < 72; i++) preload(32'h4000 + 32'(i), 8'($urandom));
    for (int i = 0; i < 24; i++) begin
      kind = int'($urandom_range(0, 2));
      l = 3'($urandom_range(0, 7));
      n = eff_len(l);
      a = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                     : 32'h4000 + 32'($urandom_range(0, 63));
      st = -1; sc = 0;
      if ($urandom_range(0, 2) == 0) begin
        st = int'($urandom_range(0, (kind == 2) ? n - 1 : n));
        sc = int'($urandom_range(1, 3));
      end
      run_txn($sformatf("rand%0d_k%0d", i, kind), kind, a, l, $urandom, st, sc);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_simultaneous();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
